pid_cfg_sched: RTL and testbench



---
 rtl/pid_cfg_sched_if.sv | 40 ++++
 rtl/pid_cfg_sched.sv | 144 ++++++++++++++
 tb/tb_pid_cfg_sched.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_cfg_sched_if.sv
// Bundle of host config, ECU trigger, FOC loop handshake and PID write ports
// shared between the scheduler (slave) and its surroundings (master).
interface pid_cfg_sched_if #(
  parameter int D_WIDTH = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic               cfg_sel;
  logic [D_WIDTH-1:0] cfg_addr;
  logic [D_WIDTH-1:0] cfg_data;
  logic               cfg_commit;
  logic               cfg_done;
  logic               loop_trig;
  logic               loop_ready;
  logic               loop_done;
  logic               loop_valid;
  logic               pid_d_wen;
  logic [D_WIDTH-1:0] pid_d_addr;
  logic [D_WIDTH-1:0] pid_d_data;
  logic               pid_q_wen;
  logic [D_WIDTH-1:0] pid_q_addr;
  logic [D_WIDTH-1:0] pid_q_data;
  logic               trig_overrun;

  modport slave (
    input  cfg_valid, cfg_sel, cfg_addr, cfg_data, cfg_commit,
    input  loop_trig, loop_ready, loop_done,
    output cfg_ready, cfg_done, loop_valid, trig_overrun,
    output pid_d_wen, pid_d_addr, pid_d_data,
    output pid_q_wen, pid_q_addr, pid_q_data
  );

  modport master (
    output cfg_valid, cfg_sel, cfg_addr, cfg_data, cfg_commit,
    output loop_trig, loop_ready, loop_done,
    input  cfg_ready, cfg_done, loop_valid, trig_overrun,
    input  pid_d_wen, pid_d_addr, pid_d_data,
    input  pid_q_wen, pid_q_addr, pid_q_data
  );
endinterface

// File: rtl/pid_cfg_sched.sv
// Buffers host PID writes and applies them as a committed batch only while the
// FOC loop is idle; gates ECU loop triggers, deferring or flagging overruns.
module pid_cfg_sched #(
  parameter int D_WIDTH    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  pid_cfg_sched_if.slave cfg_if
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, BUSY} state_t;
  typedef struct packed {
    logic               sel;
    logic [D_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] data;
  } entry_t;

  entry_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  state_t             state_q;
  logic               commit_armed_q, trig_pend_q;
  logic               loop_valid_q, cfg_done_q, trig_overrun_q;
  logic               d_wen_q, q_wen_q;
  logic [D_WIDTH-1:0] d_addr_q, d_data_q, q_addr_q, q_data_q;

  logic   full, ready, push, commit_in, armed, trigger, idle;
  logic   issue, start_drain, pop, last, empty_done;
  entry_t head;

  always_comb begin
    full        = (count_q == CW'(FIFO_DEPTH));
    ready       = !full && (state_q != DRAIN) && !reset;
    push        = cfg_if.cfg_valid && ready;
    commit_in   = cfg_if.cfg_commit && (state_q != DRAIN);
    armed       = commit_armed_q || commit_in;
    trigger     = cfg_if.loop_trig || trig_pend_q;
    idle        = (state_q == IDLE);
    issue       = idle && trigger && cfg_if.loop_ready;
    start_drain = idle && !issue && armed && cfg_if.loop_ready && (count_q != '0);
    pop         = start_drain || ((state_q == DRAIN) && (count_q != '0));
    // A same-cycle push extends the batch, so the entry being popped is not the last one.
    last        = pop && (count_q == CW'(1)) && !push;
    // An empty FIFO with a push in flight keeps the commit armed until the entry lands.
    empty_done  = idle && !issue && armed && (count_q == '0) && !push;
    head        = mem_q[rd_ptr_q];
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{sel: cfg_if.cfg_sel, addr: cfg_if.cfg_addr, data: cfg_if.cfg_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      commit_armed_q <= 1'b0;
      trig_pend_q    <= 1'b0;
      loop_valid_q   <= 1'b0;
      cfg_done_q     <= 1'b0;
      trig_overrun_q <= 1'b0;
      d_wen_q        <= 1'b0;
      q_wen_q        <= 1'b0;
      d_addr_q       <= '0;
      d_data_q       <= '0;
      q_addr_q       <= '0;
      q_data_q       <= '0;
    end else begin
      loop_valid_q <= 1'b0;
      cfg_done_q   <= 1'b0;
      d_wen_q      <= 1'b0;
      q_wen_q      <= 1'b0;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;

      if (last || empty_done)  commit_armed_q <= 1'b0;
      else if (commit_in)      commit_armed_q <= 1'b1;

      if (pop) begin
        if (head.sel) begin
          q_wen_q  <= 1'b1;
          q_addr_q <= head.addr;
          q_data_q <= head.data;
        end else begin
          d_wen_q  <= 1'b1;
          d_addr_q <= head.addr;
          d_data_q <= head.data;
        end
      end

      case (state_q)
        IDLE: begin
          if (issue) begin
            loop_valid_q <= 1'b1;
            trig_pend_q  <= 1'b0;
            state_q      <= BUSY;
          end else begin
            if (cfg_if.loop_trig) trig_pend_q <= 1'b1;
            if (last || empty_done) cfg_done_q <= 1'b1;
            else if (start_drain)   state_q    <= DRAIN;
          end
        end
        DRAIN: begin
          if (cfg_if.loop_trig) begin
            if (trig_pend_q) trig_overrun_q <= 1'b1;
            else             trig_pend_q    <= 1'b1;
          end
          if (last) begin
            cfg_done_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        BUSY: begin
          if (cfg_if.loop_trig) begin
            if (trig_pend_q) trig_overrun_q <= 1'b1;
            else             trig_pend_q    <= 1'b1;
          end
          if (cfg_if.loop_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_if.cfg_ready    = ready;
  assign cfg_if.cfg_done     = cfg_done_q;
  assign cfg_if.loop_valid   = loop_valid_q;
  assign cfg_if.trig_overrun = trig_overrun_q;
  assign cfg_if.pid_d_wen    = d_wen_q;
  assign cfg_if.pid_d_addr   = d_addr_q;
  assign cfg_if.pid_d_data   = d_data_q;
  assign cfg_if.pid_q_wen    = q_wen_q;
  assign cfg_if.pid_q_addr   = q_addr_q;
  assign cfg_if.pid_q_data   = q_data_q;
endmodule

// File: tb/tb_pid_cfg_sched.sv
// Directed bench for pid_cfg_sched: expected output events are queued with their
// cycle number by the stimulus and matched by an independent negedge monitor.
module tb_pid_cfg_sched;
  localparam int KD = 0, KQ = 1, KLV = 2, KDONE = 3;

  typedef struct {
    int kind;
    int cyc;
    int addr;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  pid_cfg_sched_if #(.D_WIDTH(16)) bus ();

  pid_cfg_sched #(.D_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .cfg_if (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_evt(input int kind, input int c, input int addr, input int data);
    exp_t e;
    e.kind = kind; e.cyc = c; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_evt(input int kind, input int addr, input int data);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_evt kind=%0d at cycle %0d: actual=present required=none", kind, cyc);
    end else begin
      e = sb.pop_front();
      chk("evt_kind", kind, e.kind);
      chk("evt_cycle", cyc, e.cyc);
      chk("evt_addr", addr, e.addr);
      chk("evt_data", data, e.data);
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("missed_evt_cycle", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (bus.pid_d_wen)  check_evt(KD, int'(bus.pid_d_addr), int'(bus.pid_d_data));
    if (bus.pid_q_wen)  check_evt(KQ, int'(bus.pid_q_addr), int'(bus.pid_q_data));
    if (bus.loop_valid) check_evt(KLV, 0, 0);
    if (bus.cfg_done)   check_evt(KDONE, 0, 0);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic sel, input logic [15:0] addr, input logic [15:0] data);
    bus.cfg_valid = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_addr  = addr;
    bus.cfg_data  = data;
    chk("push_ready", bus.cfg_ready, 1'b1);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {27'd0, bus.pid_d_wen, bus.pid_q_wen, bus.loop_valid,
                          bus.cfg_done, bus.trig_overrun}, 32'd0);
    chk({tag, "_d_port"}, {bus.pid_d_addr, bus.pid_d_data}, 32'd0);
    chk({tag, "_q_port"}, {bus.pid_q_addr, bus.pid_q_data}, 32'd0);
  endtask

  initial begin
    int c;
    reset          = 1'b1;
    bus.cfg_valid  = 1'b0;
    bus.cfg_sel    = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.cfg_commit = 1'b0;
    bus.loop_trig  = 1'b0;
    bus.loop_ready = 1'b1;
    bus.loop_done  = 1'b0;
    repeat (3) tick();
    chk_all_zero("in_reset");
    chk("in_reset_ready", bus.cfg_ready, 1'b0);
    reset = 1'b0;
    tick();
    chk("post_reset_ready", bus.cfg_ready, 1'b1);

    // Three-entry batch committed while idle
    push(1'b0, 16'h1, 16'h10);
    push(1'b1, 16'h2, 16'h20);
    push(1'b0, 16'h3, 16'h30);
    c = cyc;
    bus.cfg_commit = 1'b1;
    expect_evt(KD, c + 1, 1, 'h10);
    expect_evt(KQ, c + 2, 2, 'h20);
    expect_evt(KD, c + 3, 3, 'h30);
    expect_evt(KDONE, c + 3, 0, 0);
    tick();
    bus.cfg_commit = 1'b0;
    chk("drain_ready_1", bus.cfg_ready, 1'b0);
    tick();
    chk("drain_ready_2", bus.cfg_ready, 1'b0);
    tick();
    chk("after_drain_ready", bus.cfg_ready, 1'b1);
    tick();

    // Fill to capacity, then hold a fifth write that must be refused
    for (int i = 0; i < 4; i++) push(1'(i), 16'(16'h10 + i), 16'(16'hA0 + i));
    bus.cfg_valid = 1'b1;
    bus.cfg_sel   = 1'b1;
    bus.cfg_addr  = 16'h99;
    bus.cfg_data  = 16'hEE;
    chk("full_ready_1", bus.cfg_ready, 1'b0);
    tick();
    chk("full_ready_2", bus.cfg_ready, 1'b0);
    bus.cfg_valid = 1'b0;
    c = cyc;
    bus.cfg_commit = 1'b1;
    for (int i = 0; i < 4; i++) expect_evt(i % 2, c + 1 + i, 'h10 + i, 'hA0 + i);
    expect_evt(KDONE, c + 4, 0, 0);
    tick();
    bus.cfg_commit = 1'b0;
    repeat (4) tick();

    // Across the pointer wrap, with the second push landing alongside the commit
    push(1'b1, 16'h21, 16'hB1);
    bus.cfg_valid  = 1'b1;
    bus.cfg_sel    = 1'b0;
    bus.cfg_addr   = 16'h22;
    bus.cfg_data   = 16'hB2;
    bus.cfg_commit = 1'b1;
    c = cyc;
    expect_evt(KQ, c + 1, 'h21, 'hB1);
    expect_evt(KD, c + 2, 'h22, 'hB2);
    expect_evt(KDONE, c + 2, 0, 0);
    tick();
    bus.cfg_valid  = 1'b0;
    bus.cfg_commit = 1'b0;
    repeat (3) tick();

    // Commit while the loop runs; drain waits until loop_done
    c = cyc;
    bus.loop_trig = 1'b1;
    expect_evt(KLV, c + 1, 0, 0);
    tick();
    bus.loop_trig  = 1'b0;
    bus.loop_ready = 1'b0;
    push(1'b0, 16'h31, 16'hC1);
    bus.cfg_valid  = 1'b1;
    bus.cfg_sel    = 1'b1;
    bus.cfg_addr   = 16'h32;
    bus.cfg_data   = 16'hC2;
    bus.cfg_commit = 1'b1;
    chk("busy_push_ready", bus.cfg_ready, 1'b1);
    tick();
    bus.cfg_valid  = 1'b0;
    bus.cfg_commit = 1'b0;
    repeat (3) tick();
    c = cyc;
    bus.loop_done  = 1'b1;
    bus.loop_ready = 1'b1;
    expect_evt(KD, c + 2, 'h31, 'hC1);
    expect_evt(KQ, c + 3, 'h32, 'hC2);
    expect_evt(KDONE, c + 3, 0, 0);
    tick();
    bus.loop_done = 1'b0;
    repeat (4) tick();

    // Trigger in the second drain cycle is deferred until idle
    for (int i = 0; i < 4; i++) push(1'b0, 16'(16'h40 + i), 16'(16'hD0 + i));
    c = cyc;
    bus.cfg_commit = 1'b1;
    for (int i = 0; i < 4; i++) expect_evt(KD, c + 1 + i, 'h40 + i, 'hD0 + i);
    expect_evt(KDONE, c + 4, 0, 0);
    tick();
    bus.cfg_commit = 1'b0;
    tick();
    bus.loop_trig = 1'b1;
    expect_evt(KLV, c + 5, 0, 0);
    tick();
    bus.loop_trig = 1'b0;
    chk("defer_no_overrun_1", bus.trig_overrun, 1'b0);
    repeat (3) tick();
    chk("defer_no_overrun_2", bus.trig_overrun, 1'b0);

    // Two triggers in BUSY: second one is an overrun, one start follows loop_done
    bus.loop_trig = 1'b1;
    tick();
    bus.loop_trig = 1'b0;
    tick();
    chk("one_pend_no_overrun", bus.trig_overrun, 1'b0);
    bus.loop_trig = 1'b1;
    tick();
    bus.loop_trig = 1'b0;
    chk("overrun_set", bus.trig_overrun, 1'b1);
    repeat (2) tick();
    chk("overrun_sticky", bus.trig_overrun, 1'b1);
    c = cyc;
    bus.loop_done = 1'b1;
    expect_evt(KLV, c + 2, 0, 0);
    tick();
    bus.loop_done = 1'b0;
    repeat (3) tick();
    bus.loop_done = 1'b1;
    tick();
    bus.loop_done = 1'b0;
    tick();
    chk("overrun_still_set", bus.trig_overrun, 1'b1);

    // Reset after the first of three drained writes
    push(1'b1, 16'h5, 16'h50);
    push(1'b1, 16'h6, 16'h51);
    push(1'b1, 16'h7, 16'h52);
    c = cyc;
    bus.cfg_commit = 1'b1;
    expect_evt(KQ, c + 1, 5, 'h50);
    tick();
    bus.cfg_commit = 1'b0;
    reset = 1'b1;
    tick();
    chk_all_zero("mid_drain_reset");
    chk("mid_drain_reset_ready", bus.cfg_ready, 1'b0);
    reset = 1'b0;
    tick();
    chk_all_zero("after_reset");
    chk("after_reset_ready", bus.cfg_ready, 1'b1);
    c = cyc;
    bus.cfg_commit = 1'b1;
    expect_evt(KDONE, c + 1, 0, 0);
    tick();
    bus.cfg_commit = 1'b0;
    repeat (5) tick();

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
